uart_cmd_scheduler: RTL and testbench
=====================================

UART_CMD_SCHEDULER -- requirements
Module: uart_cmd_scheduler

Interface
REQ-001 The block SHALL have parameter ACK_BYTE, default 8'h6B, the acknowledge byte expected from the remote module.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 2400, the ack wait window in clk cycles (100 us at 24 MHz).
REQ-003 The block SHALL have parameter MAX_RETRIES, default 3, the number of retransmissions after the first attempt.
REQ-004 The block SHALL have ports, one per line:
 clk  in  1  system clock, single domain
 reset  in  1  asynchronous, active-low reset
 req0 / req1  in  1 each  requester command request, level
 cmd0 / cmd1  in  8 each  command byte, stable while reqN high
 done0 / done1  out  1 each  one-cycle pulse, command acknowledged
 fail0 / fail1  out  1 each  one-cycle pulse, retries exhausted
 busy  out  1  high in every state except IDLE
 start_tx  out  1  one-cycle pulse to uart_tx
 data_to_tx  out  8  byte to uart_tx
 tx_busy  in  1  from uart_tx
 data_received  in  8  from uart_rx
 rx_done  in  1  from uart_rx, one-cycle pulse
 parity_error  in  1  from uart_rx, valid with rx_done

Function
REQ-005 The FSM SHALL have states IDLE, SEND, TX_WAIT, ACK_WAIT, DONE, FAIL.
REQ-006 IDLE: the FSM SHALL sample req0/req1; if either is high, it SHALL latch the granted cmd into data_to_tx, record the grant index, clear the retry counter and go to SEND on the next edge.
REQ-007 Arbitration SHALL be round-robin: with both requests high, the requester not granted last wins; after reset, req0 wins the first tie.
REQ-008 SEND: the FSM SHALL drive start_tx high for exactly one cycle and then go to TX_WAIT; start_tx SHALL be high in the cycle after the granting IDLE cycle (latency 1).
REQ-009 TX_WAIT: the FSM SHALL ignore tx_busy for the first 2 cycles, then go to ACK_WAIT on the first cycle tx_busy is 0; the ack counter SHALL clear on entry.
REQ-010 ACK_WAIT: an rx_done with data_received==ACK_BYTE and parity_error==0 SHALL go to DONE.
REQ-011 ACK_WAIT: an rx_done with any other byte, or with parity_error==1, SHALL count as NAK and trigger a retry immediately.
REQ-012 ACK_WAIT: when the counter reaches TIMEOUT_CYCLES-1 with no rx_done, the FSM SHALL trigger a retry; a valid ack in that same cycle SHALL take priority.
REQ-013 Retry: if retries < MAX_RETRIES, the FSM SHALL increment retries and go to SEND with data_to_tx unchanged; otherwise it SHALL go to FAIL.
REQ-014 DONE/FAIL SHALL last one cycle, pulse doneN/failN of the granted requester only, and return to IDLE.
REQ-015 Total transmissions per request SHALL be at most MAX_RETRIES+1.
REQ-016 reqN is sampled only in IDLE; deasserting reqN mid-transaction SHALL NOT abort it, and done/fail SHALL still pulse.
REQ-017 A requester SHALL drop reqN on the edge after its done/fail pulse; a reqN still high in the following IDLE cycle SHALL be treated as a new request.
REQ-018 data_to_tx SHALL hold its value between grants; cmdN changes outside IDLE SHALL have no effect.
REQ-019 rx_done outside ACK_WAIT SHALL be ignored.
REQ-020 The ack counter SHALL be at least clog2(TIMEOUT_CYCLES) bits wide and SHALL NOT wrap within the window.

Reset
REQ-021 While reset==0, the FSM SHALL be in IDLE and outputs SHALL be: start_tx=0, data_to_tx=8'h00, done0=done1=fail0=fail1=0, busy=0; the retry counter, ack counter and round-robin pointer SHALL be cleared so req0 wins the first tie.
REQ-022 Reset asserted mid-transaction SHALL abort immediately with no done/fail pulse; after release, the FSM SHALL resume sampling in IDLE.

Verification
REQ-023 req0=1, cmd0=8'h2A; ack 8'h6B arrives 500 cycles after tx_busy falls -> one start_tx pulse with data 8'h2A, done0 pulse, no fail0.
REQ-024 req0 and req1 rise in the same cycle, twice in a row, with each transaction acked -> order is req0, req1, req0, req1; each done pulses only to its owner.
REQ-025 req1=1, cmd1=8'h93; no ack ever arrives -> 4 start_tx pulses, each 2400+ cycles apart, then one fail1 pulse, busy low the next cycle.
REQ-026 First reply is 8'h6B with parity_error=1, retransmission is acked cleanly -> exactly 2 start_tx pulses, then done pulse.
REQ-027 reset driven low during ACK_WAIT, then released -> all outputs at reset values asynchronously, no done/fail; a new req0 is served normally afterwards.

Source files
------------

// File: rtl/uart_cmd_scheduler.sv
// Two-requester command scheduler: grants round-robin, sends the granted byte through
// uart_tx, then waits for an acknowledge byte from uart_rx and retries on NAK or timeout.
module uart_cmd_scheduler #(
    parameter logic [7:0] ACK_BYTE       = 8'h6B,
    parameter int         TIMEOUT_CYCLES = 2400,
    parameter int         MAX_RETRIES    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] cmd0,
    input  logic [7:0] cmd1,
    output logic       done0,
    output logic       done1,
    output logic       fail0,
    output logic       fail1,
    output logic       busy,
    output logic       start_tx,
    output logic [7:0] data_to_tx,
    input  logic       tx_busy,
    input  logic [7:0] data_received,
    input  logic       rx_done,
    input  logic       parity_error
);

    // The wait counter also times the TX_WAIT guard, so it needs at least 2 bits.
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) < 2) ? 2 : $clog2(TIMEOUT_CYCLES);
    localparam int RTY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(2);
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_LIMIT  = RTY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        TX_WAIT,
        ACK_WAIT,
        DONE,
        FAIL
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   wait_cnt, wait_cnt_nxt;
    logic [RTY_W-1:0]   retries, retries_nxt;
    logic               grant, grant_nxt;
    logic               prefer1, prefer1_nxt;
    logic [7:0]         data_nxt;
    logic               pick;
    logic               retry;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            retries    <= '0;
            grant      <= 1'b0;
            prefer1    <= 1'b0;
            data_to_tx <= 8'h00;
        end else begin
            // NOTE: non-blocking, so every register sees the pre-edge value of the others.
            state      <= state_nxt;
            wait_cnt   <= wait_cnt_nxt;
            retries    <= retries_nxt;
            grant      <= grant_nxt;
            prefer1    <= prefer1_nxt;
            data_to_tx <= data_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        retries_nxt  = retries;
        grant_nxt    = grant;
        prefer1_nxt  = prefer1;
        data_nxt     = data_to_tx;
        start_tx     = 1'b0;
        done0        = 1'b0;
        done1        = 1'b0;
        fail0        = 1'b0;
        fail1        = 1'b0;
        busy         = (state != IDLE);
        retry        = 1'b0;
        pick         = (req0 && req1) ? prefer1 : req1;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant_nxt   = pick;
                    prefer1_nxt = ~pick;
                    data_nxt    = pick ? cmd1 : cmd0;
                    retries_nxt = '0;
                    state_nxt   = SEND;
                end
            end
            SEND: begin
                start_tx     = 1'b1;
                wait_cnt_nxt = '0;
                state_nxt    = TX_WAIT;
            end
            TX_WAIT: begin
                // uart_tx needs a couple of cycles to raise tx_busy after start_tx.
                if (wait_cnt < GUARD_LAST) begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end else if (!tx_busy) begin
                    wait_cnt_nxt = '0;
                    state_nxt    = ACK_WAIT;
                end
            end
            ACK_WAIT: begin
                wait_cnt_nxt = wait_cnt + CNT_W'(1);
                if (rx_done) begin
                    if (data_received == ACK_BYTE && !parity_error) begin
                        state_nxt = DONE;
                    end else begin
                        retry = 1'b1;
                    end
                end else if (wait_cnt == TMO_LAST) begin
                    retry = 1'b1;
                end
                if (retry) begin
                    if (retries < RTY_LIMIT) begin
                        retries_nxt = retries + RTY_W'(1);
                        state_nxt   = SEND;
                    end else begin
                        state_nxt = FAIL;
                    end
                end
            end
            DONE: begin
                done0     = ~grant;
                done1     = grant;
                state_nxt = IDLE;
            end
            FAIL: begin
                fail0     = ~grant;
                fail1     = grant;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_cmd_scheduler.sv
// Bench for uart_cmd_scheduler: each transaction is planned up front (responses, delays),
// a timeline model derives the expected outputs per cycle, and a compare process checks them.
module tb_uart_cmd_scheduler;

    localparam logic [7:0] ACK  = 8'h6B;
    localparam int         T    = 2400;
    localparam int         MAXR = 3;

    typedef enum int {K_ACK, K_NAKB, K_NAKP, K_TMO} kind_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [7:0] cmd0, cmd1;
    logic       done0, done1, fail0, fail1, busy, start_tx;
    logic [7:0] data_to_tx;
    logic       tx_busy;
    logic [7:0] data_received;
    logic       rx_done, parity_error;

    always #5 clk = ~clk;

    uart_cmd_scheduler #(
        .ACK_BYTE       (ACK),
        .TIMEOUT_CYCLES (T),
        .MAX_RETRIES    (MAXR)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req0          (req0),
        .req1          (req1),
        .cmd0          (cmd0),
        .cmd1          (cmd1),
        .done0         (done0),
        .done1         (done1),
        .fail0         (fail0),
        .fail1         (fail1),
        .busy          (busy),
        .start_tx      (start_tx),
        .data_to_tx    (data_to_tx),
        .tx_busy       (tx_busy),
        .data_received (data_received),
        .rx_done       (rx_done),
        .parity_error  (parity_error)
    );

    int vectors = 0;
    int miscompares = 0;

    // Expected outputs for the current cycle, written by the driver just after posedge.
    bit         chk_en = 1'b0;
    bit         e_start, e_busy, e_d0, e_d1, e_f0, e_f1;
    logic [7:0] exp_data = 8'h00;
    int         last_g = 1;

    // Event monitor, used by the literal checks of the directed scenarios.
    int ncyc = 0;
    int start_cnt, done_cnt, fail_cnt, last_start, min_gap, ev_cyc, txn_r;
    int owners[$];

    kind_t att_kind[4];
    int    att_b[4];
    int    att_d[4];
    bit    att_spur[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, ncyc, act, exp);
        end
    endtask

    task automatic clear_mon();
        start_cnt  = 0;
        done_cnt   = 0;
        fail_cnt   = 0;
        last_start = -1;
        min_gap    = 1 << 30;
        ev_cyc     = -1;
        owners.delete();
    endtask

    task automatic set_exp(input bit st, input bit bz, input bit d0, input bit d1,
                           input bit f0, input bit f1);
        e_start = st;
        e_busy  = bz;
        e_d0    = d0;
        e_d1    = d1;
        e_f0    = f0;
        e_f1    = f1;
    endtask

    task automatic set_att(input int a, input kind_t k, input int b, input int d, input bit sp);
        att_kind[a] = k;
        att_b[a]    = b;
        att_d[a]    = d;
        att_spur[a] = sp;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        req0 = 1'b0;
        req1 = 1'b0;
        tx_busy = 1'b0;
        rx_done = 1'b0;
        parity_error = 1'b0;
        set_exp(0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        ncyc++;
        if (start_tx) begin
            start_cnt++;
            if (last_start >= 0 && ncyc - last_start < min_gap) min_gap = ncyc - last_start;
            last_start = ncyc;
        end
        if (done0) begin done_cnt++; owners.push_back(0); ev_cyc = ncyc; end
        if (done1) begin done_cnt++; owners.push_back(1); ev_cyc = ncyc; end
        if (fail0) begin fail_cnt++; owners.push_back(2); ev_cyc = ncyc; end
        if (fail1) begin fail_cnt++; owners.push_back(3); ev_cyc = ncyc; end
        if (chk_en) begin
            check("start_tx",   32'(start_tx),   32'(e_start));
            check("busy",       32'(busy),       32'(e_busy));
            check("done0",      32'(done0),      32'(e_d0));
            check("done1",      32'(done1),      32'(e_d1));
            check("fail0",      32'(fail0),      32'(e_f0));
            check("fail1",      32'(fail1),      32'(e_f1));
            check("data_to_tx", 32'(data_to_tx), 32'(exp_data));
        end
    end

    // One request from IDLE to its done/fail pulse. Cycle 0 is the granting IDLE cycle.
    // Attempt a starts at s; ack wait opens at p = max(s+4, s+B+1); a reply sent in cycle
    // p+D resolves at p+D+1, silence resolves at p+T.
    task automatic run_txn(input bit rq0, input bit rq1, input logic [7:0] c0,
                           input logic [7:0] c1, input int gap, input bit mid);
        int st[4];
        int pp[4];
        int s, fin, g, n, q;
        bit acked;
        logic [7:0] cmd, nak;
        bit e_st[], i_txb[], i_rxd[], i_par[];
        logic [7:0] i_dat[];

        for (int k = 0; k < gap; k++) idle_cycle();

        g = (rq0 && rq1) ? (last_g == 0 ? 1 : 0) : (rq1 ? 1 : 0);
        last_g = g;
        cmd = (g == 1) ? c1 : c0;

        s = 1;
        fin = 0;
        n = 0;
        acked = 1'b0;
        for (int a = 0; a <= MAXR; a++) begin
            st[a] = s;
            pp[a] = (att_b[a] + 1 > 4) ? s + att_b[a] + 1 : s + 4;
            fin = (att_kind[a] == K_TMO) ? pp[a] + T : pp[a] + att_d[a] + 1;
            n = a + 1;
            if (att_kind[a] == K_ACK) begin
                acked = 1'b1;
                break;
            end
            s = fin;
        end

        e_st = new[fin + 1];
        i_txb = new[fin + 1];
        i_rxd = new[fin + 1];
        i_par = new[fin + 1];
        i_dat = new[fin + 1];
        for (int a = 0; a < n; a++) begin
            e_st[st[a]] = 1'b1;
            for (int j = 0; j < att_b[a]; j++) i_txb[st[a] + j] = 1'b1;
            if (att_spur[a]) begin
                i_rxd[st[a] + 1] = 1'b1;
                i_dat[st[a] + 1] = ACK;
            end
            if (att_kind[a] != K_TMO) begin
                q = pp[a] + att_d[a];
                do nak = 8'($urandom); while (nak == ACK);
                i_rxd[q] = 1'b1;
                i_dat[q] = (att_kind[a] == K_NAKB) ? nak : ACK;
                i_par[q] = (att_kind[a] == K_NAKP);
            end
        end

        for (int k = 0; k <= fin; k++) begin
            @(posedge clk);
            #1;
            chk_en = 1'b1;
            if (k == 0) begin
                txn_r = ncyc + 1;
                req0 = rq0;
                req1 = rq1;
                cmd0 = c0;
                cmd1 = c1;
            end
            if (k == 1) exp_data = cmd;
            if (k == 2 && mid) begin
                req0 = rq0 & 1'($urandom);
                req1 = rq1 & 1'($urandom);
                cmd0 = 8'($urandom);
                cmd1 = 8'($urandom);
            end
            if (k == fin) begin
                if (g == 0) req0 = 1'b0;
                else        req1 = 1'b0;
            end
            tx_busy = i_txb[k];
            rx_done = i_rxd[k];
            data_received = i_rxd[k] ? i_dat[k] : 8'($urandom);
            parity_error = i_rxd[k] ? i_par[k] : 1'($urandom);
            set_exp(e_st[k], k >= 1,
                    k == fin && acked && g == 0, k == fin && acked && g == 1,
                    k == fin && !acked && g == 0, k == fin && !acked && g == 1);
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", ncyc);
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        req0 = 1'b1;
        req1 = 1'b0;
        cmd0 = 8'hA5;
        cmd1 = 8'h00;
        tx_busy = 1'b0;
        rx_done = 1'b0;
        data_received = 8'h00;
        parity_error = 1'b0;
        clear_mon();

        // Held in reset with a request pending: stays idle with all outputs low.
        repeat (3) @(negedge clk);
        #1;
        check("rst_start_tx", 32'(start_tx),   0);
        check("rst_data",     32'(data_to_tx), 0);
        check("rst_busy",     32'(busy),       0);
        check("rst_done",     32'({done0, done1}), 0);
        check("rst_fail",     32'({fail0, fail1}), 0);
        req0 = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle_cycle();

        // Two simultaneous-request rounds: round-robin must serve 0,1,0,1.
        clear_mon();
        for (int a = 0; a <= MAXR; a++) set_att(a, K_ACK, 3, 7, 0);
        run_txn(1, 1, 8'h11, 8'h22, 0, 0);
        run_txn(0, 1, 8'h11, 8'h22, 0, 0);
        run_txn(1, 1, 8'h33, 8'h44, 0, 0);
        run_txn(0, 1, 8'h33, 8'h44, 0, 0);
        check("rr_count", owners.size(), 4);
        if (owners.size() == 4) begin
            check("rr_owner0", owners[0], 0);
            check("rr_owner1", owners[1], 1);
            check("rr_owner2", owners[2], 0);
            check("rr_owner3", owners[3], 1);
        end

        // Ack arrives 500 cycles after tx_busy falls (busy 5 cycles): done at offset 507.
        clear_mon();
        set_att(0, K_ACK, 5, 499, 0);
        run_txn(1, 0, 8'h2A, 8'h00, 1, 0);
        check("ack500_starts", start_cnt, 1);
        check("ack500_done", done_cnt, 1);
        check("ack500_fail", fail_cnt, 0);
        check("ack500_offset", ev_cyc - txn_r, 507);
        check("ack500_data", 32'(data_to_tx), 32'h2A);

        // No reply at all: four sends 2404 cycles apart, fail1 at offset 9617.
        clear_mon();
        for (int a = 0; a <= MAXR; a++) set_att(a, K_TMO, 1, 0, 0);
        run_txn(0, 1, 8'h00, 8'h93, 0, 0);
        check("tmo_starts", start_cnt, 4);
        check("tmo_min_gap", min_gap, 2404);
        check("tmo_fail", fail_cnt, 1);
        check("tmo_done", done_cnt, 0);
        check("tmo_offset", ev_cyc - txn_r, 9617);
        if (owners.size() == 1) check("tmo_owner", owners[0], 3);
        idle_cycle();
        @(negedge clk);
        #1;
        check("tmo_busy_after", 32'(busy), 0);

        // ACK byte with a parity error is a NAK; the resend is acked: done at offset 31.
        clear_mon();
        set_att(0, K_NAKP, 3, 10, 0);
        set_att(1, K_ACK, 3, 10, 0);
        run_txn(1, 0, 8'h3C, 8'h00, 0, 0);
        check("par_starts", start_cnt, 2);
        check("par_done", done_cnt, 1);
        check("par_offset", ev_cyc - txn_r, 31);

        // Ack in the last cycle of the window wins over the timeout; NAK at D=0 retries.
        clear_mon();
        set_att(0, K_NAKB, 0, 0, 1);
        set_att(1, K_ACK, 2, T - 1, 1);
        run_txn(0, 1, 8'h00, 8'h5E, 0, 1);
        check("edge_starts", start_cnt, 2);
        check("edge_done", done_cnt, 1);
        check("edge_fail", fail_cnt, 0);

        // Reset in the middle of ACK_WAIT: immediate abort, no pulse, pointer cleared.
        chk_en = 1'b0;
        @(posedge clk);
        #1;
        req0 = 1'b1;
        req1 = 1'b0;
        cmd0 = 8'hC4;
        tx_busy = 1'b0;
        rx_done = 1'b0;
        @(posedge clk);
        #1;
        req0 = 1'b0;
        repeat (18) begin @(posedge clk); #1; end
        check("mid_busy_before", 32'(busy), 1);
        check("mid_data_before", 32'(data_to_tx), 32'hC4);
        clear_mon();
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_busy",  32'(busy),       0);
        check("mid_rst_start", 32'(start_tx),   0);
        check("mid_rst_data",  32'(data_to_tx), 0);
        check("mid_rst_pulse", 32'({done0, done1, fail0, fail1}), 0);
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        last_g = 1;
        exp_data = 8'h00;
        idle_cycle();
        check("mid_no_pulse", done_cnt + fail_cnt, 0);
        run_txn(1, 1, 8'h71, 8'h72, 0, 0);
        check("mid_after_done", done_cnt, 1);
        if (owners.size() == 1) check("mid_after_owner", owners[0], 0);

        // Randomized traffic against the timeline model.
        for (int t = 0; t < 30; t++) begin
            int sel;
            int roll;
            kind_t kd;
            sel = $urandom_range(1, 3);
            for (int a = 0; a <= MAXR; a++) begin
                roll = $urandom_range(0, 99);
                kd = (roll < 50) ? K_ACK : (roll < 72) ? K_NAKB : (roll < 92) ? K_NAKP : K_TMO;
                set_att(a, kd, $urandom_range(0, 12),
                        ($urandom_range(0, 19) == 0) ? T - 1 : $urandom_range(0, 40),
                        $urandom_range(0, 3) == 0);
            end
            run_txn((sel & 1) != 0, (sel & 2) != 0, 8'($urandom), 8'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 1) == 1);
        end
        idle_cycle();
        @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
